dma_cfg_master: RTL and testbench
=================================

DMA_CFG_MASTER -- requirements
Module: dma_cfg_master

Interface
REQ-001 Parameter POLL_TIMEOUT, default 1024, SHALL set the maximum number of granted status-poll reads per job.
REQ-002 Parameter LOCK_RETRIES, default 4, SHALL set the maximum number of lock acquisition attempts per job.
REQ-003 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_ni  in  1  asynchronous, active-low reset.
REQ-005 req_valid_i / req_ready_o  in/out  1/1  job handshake; the job is accepted on the cycle both are high.
REQ-006 req_length_i  in  8  transfer length (1..255).
REQ-007 req_src_i, req_dst_i  in  64 each  source and destination addresses.
REQ-008 req_lock_id_i  in  32  nonzero core-lock owner ID.
REQ-009 resp_valid_o  out  1  one-cycle completion pulse.
REQ-010 resp_status_o  out  2  00 OK, 01 LOCK_FAIL, 10 TIMEOUT, 11 BAD_REQ; valid only with resp_valid_o.
REQ-011 busy_o  out  1  high from job acceptance through the resp_valid_o cycle.
REQ-012 reg_en_o, reg_we_o  out  1/1  register-bus access request and write qualifier.
REQ-013 reg_addr_o  out  8  byte address; register index = reg_addr_o[7:3], with reg_addr_o[2:0] = 0.
REQ-014 reg_wdata_o  out  64  write data; upper 32 bits always 0.
REQ-015 reg_rdata_i  in  64  read data, valid in the grant cycle.
REQ-016 reg_gnt_i  in  1  an access completes in the cycle where reg_en_o and reg_gnt_i are both high.

Function
REQ-017 Register indices SHALL be: 0 start, 1 length, 2 src_lsb, 3 src_msb, 4 dst_lsb, 5 dst_msb, 6 done, 7 core_lock, 8 end, 9 valid.
REQ-018 All reg_* outputs SHALL be registered and SHALL hold stable from assertion until grant.
REQ-019 reg_en_o SHALL deassert for at least one cycle between accesses.
REQ-020 req_ready_o SHALL be high only in IDLE.
REQ-021 The job fields SHALL be captured at acceptance; later input changes SHALL be ignored.
REQ-022 FSM states: IDLE, LOCK_CHK, LOCK_WR, LOCK_VFY, LEN, SRC_L, SRC_H, DST_L, DST_H, START, POLL, DONE_WR, CLR_START, UNLOCK, RESP.
REQ-023 If the accepted job has length 0 or lock_id 0, the FSM SHALL go directly to RESP with BAD_REQ and SHALL make no bus access.
REQ-024 LOCK_CHK: read index 7; on 0, go to LOCK_WR; on nonzero, count one attempt and repeat LOCK_CHK.
REQ-025 LOCK_WR: write lock_id to index 7, then go to LOCK_VFY.
REQ-026 LOCK_VFY: read index 7; on a value equal to lock_id, go to LEN; otherwise count one attempt and go to LOCK_CHK.
REQ-027 When attempts reach LOCK_RETRIES, the FSM SHALL go to RESP with LOCK_FAIL; it SHALL NOT write index 7.
REQ-028 LEN through DST_H SHALL write, in order: zero-extended length, src[31:0], src[63:32], dst[31:0], dst[63:32].
REQ-029 START SHALL write 1 to index 0.
REQ-030 POLL SHALL read index 9 once per grant.
REQ-031 In POLL, a nonzero read SHALL go to DONE_WR.
REQ-032 In POLL, the POLL_TIMEOUT-th zero read SHALL record TIMEOUT and go to CLR_START, skipping DONE_WR.
REQ-033 DONE_WR SHALL write 1 to index 6.
REQ-034 CLR_START SHALL write 0 to index 0.
REQ-035 UNLOCK SHALL write 0 to index 7, then go to RESP with OK or the recorded TIMEOUT.
REQ-036 RESP SHALL assert resp_valid_o for exactly one cycle, then return to IDLE.
REQ-037 The poll counter SHALL saturate and SHALL NOT wrap.
REQ-038 The attempt counter and poll counter SHALL clear on job acceptance.
REQ-039 The wait for reg_gnt_i SHALL have no bound in any state; the poll counter SHALL count only granted reads.

Reset
REQ-040 When rst_ni is low, the FSM SHALL enter IDLE asynchronously, mid-job included.
REQ-041 In reset: req_ready_o=1 after release, resp_valid_o=0, resp_status_o=0, busy_o=0, reg_en_o=0, reg_we_o=0, reg_addr_o=0, reg_wdata_o=0, counters 0.
REQ-042 An aborted job SHALL produce no response, and no unlock SHALL be issued after reset.

Verification
REQ-043 Normal: len=16, src=0x8000_1000, dst=0x8000_2000, id=5, lock reads 0 then 5, valid=1 on the 3rd poll -> writes idx7=5, idx1=16, idx2=0x8000_1000, idx3=0, idx4=0x8000_2000, idx5=0, idx0=1; 3 reads of idx9; then idx6=1, idx0=0, idx7=0; status OK.
REQ-044 Lock contention: idx7 always reads 3 -> 4 reads of idx7, no write to idx7, status LOCK_FAIL.
REQ-045 Timeout: POLL_TIMEOUT=8, valid stays 0 -> exactly 8 reads of idx9, no idx6 write, idx0=0 and idx7=0 written, status TIMEOUT.
REQ-046 Bad request: len=0 -> resp_valid_o in the 2nd cycle after acceptance, status BAD_REQ, no bus access.
REQ-047 Back-pressure: reg_gnt_i low for 5 cycles during SRC_H -> reg_addr_o=0x18 and reg_wdata_o held stable throughout, write sequence unchanged.
REQ-048 Reset during POLL -> all outputs at reset values, no resp_valid_o, next job runs normally.

Source files
------------

// File: rtl/dma_cfg_master_if.sv
// rtl/dma_cfg_master_if.sv - job handshake, completion and register-bus signals of dma_cfg_master
interface dma_cfg_master_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [7:0]  req_length_i;
    logic [63:0] req_src_i;
    logic [63:0] req_dst_i;
    logic [31:0] req_lock_id_i;
    logic        resp_valid_o;
    logic [1:0]  resp_status_o;
    logic        busy_o;
    logic        reg_en_o;
    logic        reg_we_o;
    logic [7:0]  reg_addr_o;
    logic [63:0] reg_wdata_o;
    logic [63:0] reg_rdata_i;
    logic        reg_gnt_i;

    // The DUT side: owns job acceptance, completion and the register bus requests.
    modport master (
        input  req_valid_i, req_length_i, req_src_i, req_dst_i, req_lock_id_i,
        input  reg_rdata_i, reg_gnt_i,
        output req_ready_o, resp_valid_o, resp_status_o, busy_o,
        output reg_en_o, reg_we_o, reg_addr_o, reg_wdata_o
    );

    // The environment side: submits jobs and serves register accesses.
    modport slave (
        output req_valid_i, req_length_i, req_src_i, req_dst_i, req_lock_id_i,
        output reg_rdata_i, reg_gnt_i,
        input  req_ready_o, resp_valid_o, resp_status_o, busy_o,
        input  reg_en_o, reg_we_o, reg_addr_o, reg_wdata_o
    );
endinterface

// File: rtl/dma_cfg_master.sv
// rtl/dma_cfg_master.sv - programs a DMA engine over a register bus under a core lock
module dma_cfg_master #(
    parameter int unsigned POLL_TIMEOUT = 1024,
    parameter int unsigned LOCK_RETRIES = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    dma_cfg_master_if.master bus
);
    localparam int unsigned PW = $clog2(POLL_TIMEOUT + 1);
    localparam int unsigned AW = $clog2(LOCK_RETRIES + 1);
    localparam logic [PW-1:0] POLL_MAX = PW'(POLL_TIMEOUT);
    localparam logic [AW-1:0] ATT_MAX  = AW'(LOCK_RETRIES);

    localparam logic [1:0] ST_OK        = 2'b00;
    localparam logic [1:0] ST_LOCK_FAIL = 2'b01;
    localparam logic [1:0] ST_TIMEOUT   = 2'b10;
    localparam logic [1:0] ST_BAD_REQ   = 2'b11;

    localparam logic [4:0] IDX_START = 5'd0;
    localparam logic [4:0] IDX_LEN   = 5'd1;
    localparam logic [4:0] IDX_SRC_L = 5'd2;
    localparam logic [4:0] IDX_SRC_H = 5'd3;
    localparam logic [4:0] IDX_DST_L = 5'd4;
    localparam logic [4:0] IDX_DST_H = 5'd5;
    localparam logic [4:0] IDX_DONE  = 5'd6;
    localparam logic [4:0] IDX_LOCK  = 5'd7;
    localparam logic [4:0] IDX_VALID = 5'd9;

    typedef enum logic [3:0] {
        IDLE, LOCK_CHK, LOCK_WR, LOCK_VFY, LEN, SRC_L, SRC_H, DST_L, DST_H,
        START, POLL, DONE_WR, CLR_START, UNLOCK, RESP
    } state_e;

    state_e      state_q;
    logic [7:0]  len_q;
    logic [63:0] src_q;
    logic [63:0] dst_q;
    logic [31:0] id_q;
    logic [AW-1:0] att_q;
    logic [PW-1:0] poll_q;
    logic [1:0]  status_q;
    logic        resp_valid_q;
    logic        busy_q;
    logic        ready_q;
    logic        reg_en_q;
    logic        reg_we_q;
    logic [7:0]  reg_addr_q;
    logic [63:0] reg_wdata_q;

    logic        acc_we;
    logic [4:0]  acc_idx;
    logic [31:0] acc_data;
    logic        rd_zero;
    logic        lock_match;
    logic [AW-1:0] att_d;
    logic [PW-1:0] poll_d;
    logic        att_exhausted;
    logic        poll_expired;

    // Access each bus state performs: direction, register index and 32-bit payload.
    always_comb begin
        acc_we   = 1'b1;
        acc_idx  = IDX_START;
        acc_data = 32'd0;
        case (state_q)
            LOCK_CHK:  begin acc_we = 1'b0; acc_idx = IDX_LOCK; end
            LOCK_WR:   begin acc_idx = IDX_LOCK;  acc_data = id_q; end
            LOCK_VFY:  begin acc_we = 1'b0; acc_idx = IDX_LOCK; end
            LEN:       begin acc_idx = IDX_LEN;   acc_data = {24'd0, len_q}; end
            SRC_L:     begin acc_idx = IDX_SRC_L; acc_data = src_q[31:0]; end
            SRC_H:     begin acc_idx = IDX_SRC_H; acc_data = src_q[63:32]; end
            DST_L:     begin acc_idx = IDX_DST_L; acc_data = dst_q[31:0]; end
            DST_H:     begin acc_idx = IDX_DST_H; acc_data = dst_q[63:32]; end
            START:     begin acc_idx = IDX_START; acc_data = 32'd1; end
            POLL:      begin acc_we = 1'b0; acc_idx = IDX_VALID; end
            DONE_WR:   begin acc_idx = IDX_DONE;  acc_data = 32'd1; end
            CLR_START: begin acc_idx = IDX_START; acc_data = 32'd0; end
            UNLOCK:    begin acc_idx = IDX_LOCK;  acc_data = 32'd0; end
            default:   ;
        endcase
    end

    // Read-data decode and saturating next values of the attempt and poll counters.
    always_comb begin
        rd_zero       = (bus.reg_rdata_i == 64'd0);
        lock_match    = (bus.reg_rdata_i == {32'd0, id_q});
        att_d         = (att_q == ATT_MAX) ? att_q : att_q + AW'(1);
        poll_d        = (poll_q == POLL_MAX) ? poll_q : poll_q + PW'(1);
        att_exhausted = (att_d >= ATT_MAX);
        poll_expired  = (poll_d >= POLL_MAX);
    end

    // Job sequencer: accepts a job, walks the register program and reports completion.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            len_q        <= 8'd0;
            src_q        <= 64'd0;
            dst_q        <= 64'd0;
            id_q         <= 32'd0;
            att_q        <= '0;
            poll_q       <= '0;
            status_q     <= ST_OK;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b1;
            reg_en_q     <= 1'b0;
            reg_we_q     <= 1'b0;
            reg_addr_q   <= 8'd0;
            reg_wdata_q  <= 64'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (resp_valid_q) begin
                        // Completion pulse ends here; the next job may be taken from now on.
                        resp_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        ready_q      <= 1'b1;
                    end else if (bus.req_valid_i && ready_q) begin
                        len_q    <= bus.req_length_i;
                        src_q    <= bus.req_src_i;
                        dst_q    <= bus.req_dst_i;
                        id_q     <= bus.req_lock_id_i;
                        att_q    <= '0;
                        poll_q   <= '0;
                        status_q <= ST_OK;
                        busy_q   <= 1'b1;
                        ready_q  <= 1'b0;
                        if (bus.req_length_i == 8'd0 || bus.req_lock_id_i == 32'd0) begin
                            status_q <= ST_BAD_REQ;
                            state_q  <= RESP;
                        end else begin
                            state_q  <= LOCK_CHK;
                        end
                    end
                end
                RESP: begin
                    resp_valid_q <= 1'b1;
                    state_q      <= IDLE;
                end
                default: begin
                    if (!reg_en_q) begin
                        // Launch this state's access; en was low for the cycle after the last grant.
                        reg_en_q    <= 1'b1;
                        reg_we_q    <= acc_we;
                        reg_addr_q  <= {acc_idx, 3'b000};
                        reg_wdata_q <= {32'd0, acc_data};
                    end else if (bus.reg_gnt_i) begin
                        reg_en_q <= 1'b0;
                        case (state_q)
                            LOCK_CHK: begin
                                if (rd_zero) begin
                                    state_q <= LOCK_WR;
                                end else begin
                                    att_q <= att_d;
                                    if (att_exhausted) begin
                                        status_q <= ST_LOCK_FAIL;
                                        state_q  <= RESP;
                                    end
                                end
                            end
                            LOCK_WR: state_q <= LOCK_VFY;
                            LOCK_VFY: begin
                                if (lock_match) begin
                                    state_q <= LEN;
                                end else begin
                                    att_q <= att_d;
                                    if (att_exhausted) begin
                                        status_q <= ST_LOCK_FAIL;
                                        state_q  <= RESP;
                                    end else begin
                                        state_q  <= LOCK_CHK;
                                    end
                                end
                            end
                            LEN:   state_q <= SRC_L;
                            SRC_L: state_q <= SRC_H;
                            SRC_H: state_q <= DST_L;
                            DST_L: state_q <= DST_H;
                            DST_H: state_q <= START;
                            START: state_q <= POLL;
                            POLL: begin
                                if (!rd_zero) begin
                                    state_q <= DONE_WR;
                                end else begin
                                    poll_q <= poll_d;
                                    if (poll_expired) begin
                                        status_q <= ST_TIMEOUT;
                                        state_q  <= CLR_START;
                                    end
                                end
                            end
                            DONE_WR:   state_q <= CLR_START;
                            CLR_START: state_q <= UNLOCK;
                            UNLOCK:    state_q <= RESP;
                            default:   state_q <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.req_ready_o   = ready_q;
    assign bus.resp_valid_o  = resp_valid_q;
    assign bus.resp_status_o = status_q;
    assign bus.busy_o        = busy_q;
    assign bus.reg_en_o      = reg_en_q;
    assign bus.reg_we_o      = reg_we_q;
    assign bus.reg_addr_o    = reg_addr_q;
    assign bus.reg_wdata_o   = reg_wdata_q;
endmodule

// File: tb/tb_dma_cfg_master.sv
// tb/tb_dma_cfg_master.sv - scoreboard bench for dma_cfg_master with a job-level reference model
module tb_dma_cfg_master;
    localparam int PT = 8;
    localparam int LR = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dma_cfg_master_if bus();

    dma_cfg_master #(.POLL_TIMEOUT(PT), .LOCK_RETRIES(LR)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int resp_seen = 0;

    logic [72:0] exp_acc[$];
    logic [1:0]  exp_resp[$];
    logic [63:0] lock_plan[$];
    logic [63:0] slave_lock_q[$];
    int          poll_hit = 1;
    int          slave_poll_cnt = 0;
    logic [63:0] poll_val = 64'd1;
    logic [7:0]  stall_addr = 8'hff;
    int          stall_left = 0;

    task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_rd(input int idx);
        exp_acc.push_back({1'b0, 8'(idx * 8), 64'd0});
    endtask

    task automatic exp_wr(input int idx, input logic [31:0] d);
        exp_acc.push_back({1'b1, 8'(idx * 8), 32'd0, d});
    endtask

    // Register-file slave: lock reads come from a planned list, valid goes nonzero on read poll_hit.
    task automatic slave_read(input logic [4:0] idx, output logic [63:0] v);
        v = 64'd0;
        if (idx == 5'd7) begin
            if (slave_lock_q.size() > 0) v = slave_lock_q.pop_front();
            else v = 64'd3;
        end else if (idx == 5'd9) begin
            slave_poll_cnt++;
            if (slave_poll_cnt == poll_hit) v = poll_val;
        end
    endtask

    // Reference model: the full access list and final status a job must produce.
    task automatic model_job(input logic [7:0] len, input logic [63:0] src, input logic [63:0] dst,
                             input logic [31:0] id);
        int att = 0;
        int k = 0;
        int nrd;
        bit locked = 0;
        logic [63:0] v;
        if (len == 8'd0 || id == 32'd0) begin
            exp_resp.push_back(2'd3);
            return;
        end
        while (!locked && att < LR) begin
            exp_rd(7);
            v = (k < lock_plan.size()) ? lock_plan[k] : 64'd3;
            k++;
            if (v != 64'd0) att++;
            else begin
                exp_wr(7, id);
                exp_rd(7);
                v = (k < lock_plan.size()) ? lock_plan[k] : 64'd3;
                k++;
                if (v == {32'd0, id}) locked = 1;
                else att++;
            end
        end
        if (!locked) begin
            exp_resp.push_back(2'd1);
            return;
        end
        exp_wr(1, {24'd0, len});
        exp_wr(2, src[31:0]);
        exp_wr(3, src[63:32]);
        exp_wr(4, dst[31:0]);
        exp_wr(5, dst[63:32]);
        exp_wr(0, 32'd1);
        nrd = (poll_hit <= PT) ? poll_hit : PT;
        for (int i = 0; i < nrd; i++) exp_rd(9);
        if (poll_hit <= PT) exp_wr(6, 32'd1);
        exp_wr(0, 32'd0);
        exp_wr(7, 32'd0);
        exp_resp.push_back((poll_hit <= PT) ? 2'd0 : 2'd2);
    endtask

    // Bus responder: decides grant and read data just after each rising edge.
    always begin
        logic [63:0] rd;
        @(posedge clk);
        #1;
        bus.reg_gnt_i   = 1'b0;
        bus.reg_rdata_i = {$urandom, $urandom};
        if (rst_n && bus.reg_en_o) begin
            if (stall_left > 0 && bus.reg_addr_o == stall_addr) begin
                stall_left--;
            end else begin
                bus.reg_gnt_i = ($urandom_range(0, 3) != 0);
                if (bus.reg_gnt_i && !bus.reg_we_o) begin
                    slave_read(bus.reg_addr_o[7:3], rd);
                    bus.reg_rdata_i = rd;
                end
            end
        end
    end

    // Monitor: compares every granted access and every completion against the scoreboard.
    logic        p_en = 1'b0;
    logic        p_gnt = 1'b0;
    logic        p_we = 1'b0;
    logic [7:0]  p_addr = 8'd0;
    logic [63:0] p_wd = 64'd0;
    always @(negedge clk) begin
        logic [72:0] e;
        logic [72:0] a;
        if (!rst_n) begin
            p_en  = 1'b0;
            p_gnt = 1'b0;
        end else begin
            if (p_en && !p_gnt && bus.reg_en_o)
                check("hold_stable", {bus.reg_we_o, bus.reg_addr_o, bus.reg_wdata_o}, {p_we, p_addr, p_wd});
            if (p_en && p_gnt)
                check("en_gap", bus.reg_en_o, 1'b0);
            if (bus.reg_en_o && bus.reg_gnt_i) begin
                a = {bus.reg_we_o, bus.reg_addr_o, bus.reg_we_o ? bus.reg_wdata_o : 64'd0};
                if (exp_acc.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_access: got %h expected none", a);
                end else begin
                    e = exp_acc.pop_front();
                    check("access", a, e);
                end
            end
            if (bus.resp_valid_o) begin
                resp_seen++;
                check("busy_at_resp", bus.busy_o, 1'b1);
                if (exp_resp.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_resp: got status %0d expected none", bus.resp_status_o);
                end else begin
                    check("resp_status", bus.resp_status_o, exp_resp.pop_front());
                end
            end
            p_en   = bus.reg_en_o;
            p_gnt  = bus.reg_gnt_i;
            p_we   = bus.reg_we_o;
            p_addr = bus.reg_addr_o;
            p_wd   = bus.reg_wdata_o;
        end
    end

    task automatic issue_job(input logic [7:0] len, input logic [63:0] src, input logic [63:0] dst,
                             input logic [31:0] id);
        int guard = 0;
        @(negedge clk);
        while (!bus.req_ready_o && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready", bus.req_ready_o, 1'b1);
        bus.req_valid_i   = 1'b1;
        bus.req_length_i  = len;
        bus.req_src_i     = src;
        bus.req_dst_i     = dst;
        bus.req_lock_id_i = id;
        @(posedge clk);
        #1;
        bus.req_valid_i   = 1'b0;
        bus.req_length_i  = 8'($urandom);
        bus.req_src_i     = {$urandom, $urandom};
        bus.req_dst_i     = {$urandom, $urandom};
        bus.req_lock_id_i = $urandom;
    endtask

    task automatic run_job(input logic [7:0] len, input logic [63:0] src, input logic [63:0] dst,
                           input logic [31:0] id, input bit bad_timing);
        int target;
        int guard = 0;
        slave_lock_q   = lock_plan;
        slave_poll_cnt = 0;
        model_job(len, src, dst, id);
        target = resp_seen + 1;
        issue_job(len, src, dst, id);
        if (bad_timing) begin
            @(negedge clk);
            check("bad_req_cycle1_valid", bus.resp_valid_o, 1'b0);
            check("bad_req_cycle1_busy", bus.busy_o, 1'b1);
            @(negedge clk);
            check("bad_req_cycle2_valid", bus.resp_valid_o, 1'b1);
        end
        while (resp_seen < target && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        check("resp_received", (resp_seen >= target), 1'b1);
        check("accesses_left", exp_acc.size(), 0);
    endtask

    initial begin
        int r0;
        int guard;
        bus.req_valid_i   = 1'b0;
        bus.req_length_i  = 8'd0;
        bus.req_src_i     = 64'd0;
        bus.req_dst_i     = 64'd0;
        bus.req_lock_id_i = 32'd0;
        bus.reg_gnt_i     = 1'b0;
        bus.reg_rdata_i   = 64'd0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", bus.resp_valid_o, 1'b0);
        check("rst_status", bus.resp_status_o, 2'd0);
        check("rst_busy", bus.busy_o, 1'b0);
        check("rst_reg_en", bus.reg_en_o, 1'b0);
        check("rst_reg_we", bus.reg_we_o, 1'b0);
        check("rst_reg_addr", bus.reg_addr_o, 8'd0);
        check("rst_reg_wdata", bus.reg_wdata_o, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", bus.req_ready_o, 1'b1);

        lock_plan = '{64'd0, 64'd5};
        poll_hit  = 3;
        poll_val  = 64'd1;
        run_job(8'd16, 64'h8000_1000, 64'h8000_2000, 32'd5, 1'b0);

        lock_plan = '{64'd3, 64'd3, 64'd3, 64'd3, 64'd3, 64'd3, 64'd3, 64'd3};
        run_job(8'd40, 64'h1234_5678_9abc_def0, 64'h0fed_cba9_8765_4321, 32'd9, 1'b0);

        lock_plan = '{64'd0, 64'd7};
        poll_hit  = 1000;
        run_job(8'd255, 64'hffff_ffff_0000_0001, 64'h0000_0001_ffff_fffe, 32'd7, 1'b0);

        lock_plan = {};
        poll_hit  = 1;
        run_job(8'd0, 64'h10, 64'h20, 32'd5, 1'b1);
        run_job(8'd10, 64'h10, 64'h20, 32'd0, 1'b1);

        lock_plan  = '{64'd0, 64'd6};
        poll_hit   = 2;
        stall_addr = 8'h18;
        stall_left = 5;
        run_job(8'd1, 64'hdead_beef_cafe_f00d, 64'h0123_4567_89ab_cdef, 32'd6, 1'b0);
        check("stall_consumed", stall_left, 0);
        stall_addr = 8'hff;

        lock_plan      = '{64'd0, 64'd11};
        poll_hit       = 1000;
        slave_lock_q   = lock_plan;
        slave_poll_cnt = 0;
        model_job(8'd20, 64'h100, 64'h200, 32'd11);
        r0 = resp_seen;
        issue_job(8'd20, 64'h100, 64'h200, 32'd11);
        guard = 0;
        while (slave_poll_cnt < 3 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("reached_poll", (slave_poll_cnt >= 3), 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_resp_valid", bus.resp_valid_o, 1'b0);
        check("mid_rst_status", bus.resp_status_o, 2'd0);
        check("mid_rst_busy", bus.busy_o, 1'b0);
        check("mid_rst_reg_en", bus.reg_en_o, 1'b0);
        check("mid_rst_reg_we", bus.reg_we_o, 1'b0);
        check("mid_rst_reg_addr", bus.reg_addr_o, 8'd0);
        check("mid_rst_reg_wdata", bus.reg_wdata_o, 64'd0);
        exp_acc.delete();
        exp_resp.delete();
        slave_lock_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", bus.req_ready_o, 1'b1);
        repeat (6) @(negedge clk);
        check("no_resp_after_rst", resp_seen, r0);

        lock_plan = '{64'd0, 64'd5};
        poll_hit  = 3;
        run_job(8'd16, 64'h8000_1000, 64'h8000_2000, 32'd5, 1'b0);

        for (int j = 0; j < 40; j++) begin
            logic [7:0]  len;
            logic [31:0] id;
            int          r;
            len = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            id  = $urandom;
            if (id == 32'd0) id = 32'd1;
            if ($urandom_range(0, 9) == 0) id = 32'd0;
            lock_plan = {};
            for (int i = 0; i < 2 * LR; i++) begin
                r = $urandom_range(0, 9);
                if (r < 4) lock_plan.push_back(64'd0);
                else if (r < 8) lock_plan.push_back({32'd0, id});
                else lock_plan.push_back({32'd1, id});
            end
            poll_hit = $urandom_range(1, PT + 2);
            poll_val = 64'd1 << $urandom_range(0, 63);
            run_job(len, {$urandom, $urandom}, {$urandom, $urandom}, id, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
